// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned 16-bit multiply/divide for the RISC datapath.
// One operation at a time: accept in IDLE, ITER iterations in RUN, one-cycle done in DONE.
// The result, its destination address and err are held until a later operation completes.
// Optional feature macro: MULDIV_DIV_EN builds the restoring divider. Without it, divide
// ops complete immediately with result 0 and err=1.
module muldiv_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [2:0]       i_dest_addr,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [2:0]       o_result_addr,
    output logic             o_err
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] OpMulLo = 2'b00;
    localparam logic [1:0] OpMulHi = 2'b01;
    localparam logic [1:0] OpDivQ  = 2'b10;
    localparam logic [1:0] OpDivR  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e r_state, w_state_next;

    logic [1:0]         r_op;
    logic [2:0]         r_dest;
    logic [CntW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [2:0]         r_result_addr;
    logic               r_err;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_final_result;
    logic               w_final_err;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out of the top, quotient bits in
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH:0]     w_shift;    // 17-bit partial remainder for this step
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_unused_diff_msb;
`endif

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_run    = (r_state == StRun);
    assign w_last   = w_run && (r_cnt == CntW'(ITER - 1));

    // Shift-add step: the multiplicand is pre-shifted, so add it when the current bit is set
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MULDIV_DIV_EN
    // Restoring divide step; a zero divisor always "fits", giving all-ones quotient and
    // leaving the dividend in the remainder
    assign w_shift           = {r_rem, r_quo[WIDTH-1]};
    assign w_diff            = w_shift - {1'b0, r_divisor};
    assign w_ge              = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next        = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next        = {r_quo[WIDTH-2:0], w_ge};
    assign w_unused_diff_msb = w_diff[WIDTH];
`endif

    // Select the final result from the last iteration's next values
    always_comb begin
        w_final_result = '0;
        w_final_err    = 1'b0;
        case (r_op)
            OpMulLo: w_final_result = w_acc_next[WIDTH-1:0];
            OpMulHi: w_final_result = w_acc_next[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            OpDivQ: begin
                w_final_result = w_quo_next;
                w_final_err    = (r_divisor == '0);
            end
            OpDivR: begin
                w_final_result = w_rem_next;
                w_final_err    = (r_divisor == '0);
            end
`endif
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
`ifdef MULDIV_DIV_EN
                    w_state_next = StRun;
`else
                    w_state_next = i_op[1] ? StDone : StRun;
`endif
                end
            end
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand capture, per-cycle iteration and result latching
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op          <= '0;
            r_dest        <= '0;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_result_addr <= '0;
            r_err         <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_divisor     <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
`endif
        end else if (w_accept) begin
            r_op     <= i_op;
            r_dest   <= i_dest_addr;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_op_a};
            r_mplier <= i_op_b;
            r_acc    <= '0;
`ifdef MULDIV_DIV_EN
            r_divisor <= i_op_b;
            r_quo     <= i_op_a;
            r_rem     <= '0;
`else
            // No divider: divide ops finish straight away with an error
            if (i_op[1]) begin
                r_result      <= '0;
                r_result_addr <= i_dest_addr;
                r_err         <= 1'b1;
            end
`endif
        end else if (w_run) begin
            r_cnt    <= r_cnt + CntW'(1);
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`ifdef MULDIV_DIV_EN
            r_quo    <= w_quo_next;
            r_rem    <= w_rem_next;
`endif
            if (w_last) begin
                r_result      <= w_final_result;
                r_result_addr <= r_dest;
                r_err         <= w_final_err;
            end
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_result      = r_result;
    assign o_result_addr = r_result_addr;
    assign o_err         = r_err;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, start-spam and mid-run reset sequences, then
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  dest;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  result_addr;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULDIV_DIV_EN
    localparam int DivLat = 16;
`else
    localparam int DivLat = 0;
`endif

    muldiv_unit #(
        .WIDTH(16),
        .ITER (16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_op         (op),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .i_dest_addr  (dest),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_result_addr(result_addr),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands; latency counted in edges after accept
    function automatic void model(input logic [1:0] o, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic e, output int lat);
        logic [31:0] p;
        p   = {16'h0, a} * {16'h0, b};
        e   = 1'b0;
        lat = 16;
        r   = 16'h0;
        case (o)
            2'b00: r = p[15:0];
            2'b01: r = p[31:16];
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 16'h0) begin
                    e = 1'b1;
                    r = o[0] ? a : 16'hFFFF;
                end else begin
                    r = o[0] ? (a % b) : (a / b);
                end
`else
                r   = 16'h0;
                e   = 1'b1;
                lat = 0;
`endif
            end
        endcase
    endfunction

    // Issue one op (called at posedge+1 with the unit idle), scramble inputs after accept
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] d,
                          input logic [15:0] er, input logic ee, input int el);
        int cyc;
        op = o; op_a = a; op_b = b; dest = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom_range(3));
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        dest  = 3'($urandom_range(7));
        check({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, el);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " addr"}, 32'(result_addr), 32'(d));
        check({tag, " err"}, 32'(err), 32'(ee));
        @(posedge clk); #1;
        check({tag, " done low"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " held"}, 32'(result), 32'(er));
    endtask

    vec_t tbl[10];

    initial begin
        logic [15:0] er;
        logic        ee;
        int          el;
        int          cyc;
        bit          seen_done;

        tbl[0] = '{2'b00, 16'h1234, 16'h0056, 3'd3, 16'h1D78, 1'b0, 16};
        tbl[1] = '{2'b01, 16'h1234, 16'h0056, 3'd3, 16'h0006, 1'b0, 16};
        tbl[2] = '{2'b01, 16'hFFFF, 16'hFFFF, 3'd7, 16'hFFFE, 1'b0, 16};
        tbl[3] = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001, 1'b0, 16};
        tbl[4] = '{2'b01, 16'h8000, 16'h0002, 3'd5, 16'h0001, 1'b0, 16};
        tbl[5] = '{2'b00, 16'h0000, 16'hFFFF, 3'd0, 16'h0000, 1'b0, 16};
`ifdef MULDIV_DIV_EN
        tbl[6] = '{2'b10, 16'd1000, 16'd7, 3'd2, 16'h008E, 1'b0, DivLat};
        tbl[7] = '{2'b11, 16'd1000, 16'd7, 3'd4, 16'h0006, 1'b0, DivLat};
        tbl[8] = '{2'b10, 16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b1, DivLat};
        tbl[9] = '{2'b11, 16'h1234, 16'h0000, 3'd2, 16'h1234, 1'b1, DivLat};
`else
        tbl[6] = '{2'b10, 16'd1000, 16'd7, 3'd2, 16'h0000, 1'b1, DivLat};
        tbl[7] = '{2'b11, 16'd1000, 16'd7, 3'd4, 16'h0000, 1'b1, DivLat};
        tbl[8] = '{2'b10, 16'h1234, 16'h0000, 3'd6, 16'h0000, 1'b1, DivLat};
        tbl[9] = '{2'b11, 16'h1234, 16'h0000, 3'd2, 16'h0000, 1'b1, DivLat};
`endif

        reset = 1'b1; start = 1'b0; op = 2'b00; op_a = 16'h0; op_b = 16'h0; dest = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset addr", 32'(result_addr), 32'd0);
        check("reset err", 32'(err), 32'd0);

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest,
                   tbl[i].exp_res, tbl[i].exp_err, tbl[i].exp_lat);
        end

        // start held high every cycle with changing operands: only the first op runs
        op = 2'b00; op_a = 16'h00FF; op_b = 16'h0101; dest = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 40) begin
            op    = 2'($urandom_range(3));
            op_a  = 16'($urandom);
            op_b  = 16'($urandom);
            dest  = 3'($urandom_range(7));
            start = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check("spam latency", cyc, 16);
        check("spam result", 32'(result), 32'h0000FFFF);
        check("spam addr", 32'(result_addr), 32'd4);
        check("spam err", 32'(err), 32'd0);
        // start is still high in the done cycle and must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        check("spam done-cycle start ignored", 32'(busy), 32'd0);
        check("spam done low", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("spam held %0d", k), 32'(result), 32'h0000FFFF);
        end

        // Reset after iteration 8 aborts silently
        op = 2'b00; op_a = 16'h1234; op_b = 16'h0056; dest = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort addr", 32'(result_addr), 32'd0);
        check("abort err", 32'(err), 32'd0);
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort no done pulse", 32'(seen_done), 32'd0);

        // Random operations against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  ro;
            logic [15:0] ra;
            logic [15:0] rb;
            logic [2:0]  rd;
            ro = 2'($urandom_range(3));
            ra = 16'($urandom);
            rb = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
            rd = 3'($urandom_range(7));
            model(ro, ra, rb, er, ee, el);
            run_op($sformatf("rnd%0d", n), ro, ra, rb, rd, er, ee, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle unsigned multiply/divide unit for the 16-bit RISC datapath. It sits downstream of the 8-entry register file:
- It takes `readData1`/`readData2` as operands.
- It returns a 16-bit result with its destination register address, to be written back through the register file's `writeEn`/`writeAddr`/`writeData` port.
- The control unit starts it with a one-cycle `start` and stalls on `busy` until `done`.

## Interface
Parameters:
- WIDTH, 16, operand/result width; the design is only verified at 16.
- ITER, WIDTH, iteration count per operation; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULLO, 01 MULHI, 10 DIVQ (quotient), 11 DIVR (remainder).
- opA  in  16  multiplicand / dividend (register file readData1).
- opB  in  16  multiplier / divisor (register file readData2).
- destAddr  in  3  destination register, 0..7.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; doubles as write-back enable.
- result  out  16  result; held until the next accepted start.
- resultAddr  out  3  latched destAddr; held with result.
- err  out  1  divide-by-zero or unsupported op; valid with done, held with result.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE: `start`=1 latches op, opA, opB and destAddr, clears the counter, and moves to RUN.
  - RUN: performs one iteration per cycle. It moves to DONE after the iteration with counter = ITER-1.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in RUN and DONE; there is no queueing.
- Input changes after the accept edge have no effect.
- MULLO/MULHI:
  - Unsigned shift-add into a 32-bit accumulator, one multiplier bit per cycle, LSB first.
  - MULLO returns product[15:0]; MULHI returns product[31:16].
- DIVQ/DIVR:
  - Unsigned restoring division, one quotient bit per cycle, MSB first, with a 17-bit partial remainder.
  - DIVQ returns the quotient; DIVR returns the remainder.
- Divide by zero (opB=0 with op 1x):
  - Same latency as a normal divide.
  - DIVQ returns 0xFFFF; DIVR returns opA; err=1.
- err=0 for all multiplies and for divides with a nonzero divisor.
- All arithmetic is unsigned, and no intermediate value is truncated before the final select.

## Timing
- Reset values (all outputs): busy=0, done=0, result=0x0000, resultAddr=0, err=0; state is IDLE.
- Edge E0 accepts start. After E0, busy=1.
- Edges E1..E16 perform iterations 0..15.
- After E16: state DONE; done=1; result, resultAddr and err are valid.
- After E17: IDLE, done=0, busy=0.
- Latency is 16 cycles from the accept edge to done. The earliest next accept is E18, so throughput is one operation per 18 cycles.
- A start on the same cycle as done is ignored, because the unit is still in DONE.
- reset mid-operation (any state):
  - At the next edge the unit returns to IDLE and all outputs take their reset values.
  - No done pulse is produced and the aborted result is discarded.
- reset has priority over start.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: the divider is built and the DIVQ/DIVR behaviour above applies.
- Undefined:
  - The divider logic is omitted.
  - op 10/11 still accepts. It goes IDLE→DONE directly, so done is asserted one cycle after the accept edge, with result=0x0000 and err=1.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MULLO 0x1234×0x0056, dest 3 -> done 16 cycles after accept, result 0x1D78, resultAddr 3, err 0. Repeat with MULHI -> 0x0006.
- MULHI 0xFFFF×0xFFFF -> result 0xFFFE. MULLO of the same operands -> 0x0001.
- DIVQ 1000/7 -> 0x008E. DIVR 1000/7 -> 0x0006. err 0 for both.
- DIVQ 0x1234/0 -> 0xFFFF, err 1. DIVR 0x1234/0 -> 0x1234, err 1. Both with 16-cycle latency.
- Pulse start every cycle during an operation with different operands -> only the first operation executes. Result is unchanged and held stable after done until the next accept.
- Assert reset after iteration 8 -> busy 0, result 0x0000, no done pulse. Without `MULDIV_DIV_EN`, DIVQ -> done one cycle after accept, result 0x0000, err 1.
